// File: rtl/cheri_cap_mem_splitter.sv
// rtl/cheri_cap_mem_splitter.sv - splits a 128-bit capability access into two tagged memory beats
module cheri_cap_mem_splitter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [2*DATA_WIDTH-1:0] req_cap_i,
    input  logic [TAG_WIDTH-1:0]    req_tag_i,
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic                    mem_req_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata_o,
    output logic [TAG_WIDTH-1:0]    mem_req_wuser_o,
    input  logic                    mem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata_i,
    input  logic [TAG_WIDTH-1:0]    mem_rsp_ruser_i,
    input  logic                    mem_rsp_err_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [2*DATA_WIDTH-1:0] rsp_cap_o,
    output logic [TAG_WIDTH-1:0]    rsp_tag_o,
    output logic                    rsp_err_o,
    output logic                    rsp_misaligned_o
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_LO,
        WAIT_LO,
        ISSUE_HI,
        WAIT_HI,
        RESP
    } state_t;

    state_t                  state;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2*DATA_WIDTH-1:0] cap_q;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic [TAG_WIDTH-1:0]    lo_tag_q;
    logic [TAG_WIDTH-1:0]    hi_tag_q;
    logic                    err_q;
    logic                    mis_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            cap_q    <= '0;
            tag_q    <= '0;
            lo_tag_q <= '0;
            hi_tag_q <= '0;
            err_q    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        we_q     <= req_we_i;
                        addr_q   <= req_addr_i;
                        cap_q    <= req_cap_i;
                        tag_q    <= req_tag_i;
                        lo_tag_q <= '0;
                        hi_tag_q <= '0;
                        err_q    <= 1'b0;
                        // A capability must sit on a 16-byte boundary; anything else faults without touching memory
                        if (req_addr_i[3:0] != 4'h0) begin
                            mis_q <= 1'b1;
                            state <= RESP;
                        end else begin
                            mis_q <= 1'b0;
                            state <= ISSUE_LO;
                        end
                    end
                end
                ISSUE_LO: if (mem_req_ready_i) state <= WAIT_LO;
                WAIT_LO: begin
                    if (mem_rsp_valid_i) begin
                        if (mem_rsp_err_i) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end else begin
                            cap_q[DATA_WIDTH-1:0] <= mem_rsp_rdata_i;
                            lo_tag_q              <= mem_rsp_ruser_i;
                            state                 <= ISSUE_HI;
                        end
                    end
                end
                ISSUE_HI: if (mem_req_ready_i) state <= WAIT_HI;
                WAIT_HI: begin
                    if (mem_rsp_valid_i) begin
                        cap_q[2*DATA_WIDTH-1:DATA_WIDTH] <= mem_rsp_rdata_i;
                        hi_tag_q                         <= mem_rsp_ruser_i;
                        err_q                            <= mem_rsp_err_i;
                        state                            <= RESP;
                    end
                end
                RESP: if (rsp_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic issuing;
    logic load_ok;

    assign issuing = (state == ISSUE_LO) || (state == ISSUE_HI);
    // Only a clean load returns data; stores, faults and errors report an untagged zero capability
    assign load_ok = (state == RESP) && !we_q && !err_q && !mis_q;

    assign req_ready_o     = (state == IDLE);
    assign mem_req_valid_o = issuing;
    assign mem_req_we_o    = we_q;
    assign mem_req_addr_o  = (state == ISSUE_HI) ? addr_q + ADDR_WIDTH'(8) :
                             (state == ISSUE_LO) ? addr_q : '0;
    assign mem_req_wdata_o = (state == ISSUE_HI) ? cap_q[2*DATA_WIDTH-1:DATA_WIDTH] :
                             (state == ISSUE_LO) ? cap_q[DATA_WIDTH-1:0] : '0;
    assign mem_req_wuser_o = (issuing && we_q) ? tag_q : '0;

    assign rsp_valid_o      = (state == RESP);
    assign rsp_cap_o        = load_ok ? cap_q : '0;
    assign rsp_tag_o        = load_ok ? (lo_tag_q & hi_tag_q) : '0;
    assign rsp_err_o        = (state == RESP) && err_q;
    assign rsp_misaligned_o = (state == RESP) && mis_q;

endmodule
